// File: rtl/comp_mult_seq_if.sv
// Val-rdy channels around the complex multiplier operand sequencer:
// sample input, operand issue, result return and buffered result output.
interface comp_mult_seq_if #(
  parameter int DWIDTH = 8
);
  logic                  in_val;
  logic                  in_rdy;
  logic [2*DWIDTH-1:0]   in_data;
  logic                  op_val;
  logic                  op_rdy;
  logic [4*DWIDTH-1:0]   op_data;
  logic                  res_val;
  logic                  res_rdy;
  logic [4*DWIDTH+3:0]   res_data;
  logic                  out_val;
  logic                  out_rdy;
  logic [4*DWIDTH+3:0]   out_data;

  modport slave (
    input  in_val, in_data, op_rdy, res_val, res_data, out_rdy,
    output in_rdy, op_val, op_data, res_rdy, out_val, out_data
  );

  modport master (
    output in_val, in_data, op_rdy, res_val, res_data, out_rdy,
    input  in_rdy, op_val, op_data, res_rdy, out_val, out_data
  );
endinterface

// File: rtl/comp_mult_seq.sv
// Pairs input samples into multiplier operands, issues them under a credit
// limit, and buffers returned results in a circular FIFO.
module comp_mult_seq #(
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sw_rst,
  comp_mult_seq_if.slave bus,
  output logic           err
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = 2 * DWIDTH;
  localparam int OW = 4 * DWIDTH;
  localparam int RW = 4 * DWIDTH + 4;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_S = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [1:0] S_A     = 2'd0;
  localparam logic [1:0] S_B     = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [1:0]    state_r;
  logic [SW-1:0] first_r;
  logic [OW-1:0] op_data_r;
  logic          hold_r;
  logic [CW-1:0] outst_r;
  logic [CW-1:0] cnt_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic          err_r;
  logic [RW-1:0] mem_r [FIFO_DEPTH];

  logic          in_rdy_s;
  logic          op_val_s;
  logic          credit_ok_s;
  logic          res_rdy_s;
  logic          out_val_s;
  logic          in_fire_s;
  logic          op_fire_s;
  logic          res_fire_s;
  logic          pop_s;
  logic          res_matched_s;
  logic [CW:0]   committed_s;
  logic [CW-1:0] outst_nxt_s;
  logic [CW-1:0] cnt_nxt_s;

  // Credit and handshake qualification; slots already owed to in-flight ops count as used
  always_comb begin
    committed_s   = {1'b0, cnt_r} + {1'b0, outst_r};
    credit_ok_s   = (committed_s < DEPTH_S);
    res_rdy_s     = (cnt_r < DEPTH_C);
    out_val_s     = (cnt_r != CNT_ZERO);
    in_fire_s     = bus.in_val & in_rdy_s;
    op_fire_s     = op_val_s & bus.op_rdy;
    res_fire_s    = bus.res_val & res_rdy_s;
    pop_s         = out_val_s & bus.out_rdy;
    res_matched_s = res_fire_s & (outst_r != CNT_ZERO);
  end

  // State decode for input ready and operand valid; hold_r keeps op_val up once offered
  always_comb begin
    in_rdy_s = 1'b0;
    op_val_s = 1'b0;
    case (state_r)
      S_A:     in_rdy_s = 1'b1;
      S_B:     in_rdy_s = 1'b1;
      S_ISSUE: op_val_s = credit_ok_s | hold_r;
      default: begin
        in_rdy_s = 1'b0;
        op_val_s = 1'b0;
      end
    endcase
  end

  // Next outstanding count; an unmatched result leaves it at zero
  always_comb begin
    outst_nxt_s = outst_r;
    case ({op_fire_s, res_matched_s})
      2'b10:   outst_nxt_s = outst_r + CNT_ONE;
      2'b01:   outst_nxt_s = outst_r - CNT_ONE;
      default: outst_nxt_s = outst_r;
    endcase
  end

  // Next FIFO occupancy from push/pop
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({res_fire_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Pairing FSM and operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_A;
      first_r   <= '0;
      op_data_r <= '0;
      hold_r    <= 1'b0;
    end else if (sw_rst) begin
      state_r   <= S_A;
      first_r   <= '0;
      op_data_r <= '0;
      hold_r    <= 1'b0;
    end else begin
      hold_r <= op_val_s & ~bus.op_rdy;
      case (state_r)
        S_A: begin
          if (in_fire_s) begin
            first_r <= bus.in_data;
            state_r <= S_B;
          end
        end
        S_B: begin
          if (in_fire_s) begin
            op_data_r <= {first_r, bus.in_data};
            state_r   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_fire_s) begin
            state_r <= S_A;
          end
        end
        default: state_r <= S_A;
      endcase
    end
  end

  // Outstanding credit counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_r <= CNT_ZERO;
      err_r   <= 1'b0;
    end else if (sw_rst) begin
      outst_r <= CNT_ZERO;
      err_r   <= 1'b0;
    end else begin
      outst_r <= outst_nxt_s;
      if (res_fire_s && (outst_r == CNT_ZERO)) begin
        err_r <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= CNT_ZERO;
    end else if (sw_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (res_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are masked at the output while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (res_fire_s && !sw_rst) begin
      mem_r[wr_ptr_r] <= bus.res_data;
    end
  end

  assign bus.in_rdy   = in_rdy_s;
  assign bus.op_val   = op_val_s;
  assign bus.op_data  = op_data_r;
  assign bus.res_rdy  = res_rdy_s;
  assign bus.out_val  = out_val_s;
  assign bus.out_data = out_val_s ? mem_r[rd_ptr_r] : '0;
  assign err          = err_r;

endmodule

// File: tb/tb_comp_mult_seq.sv
// Randomized bench for comp_mult_seq with a queue-based reference model and a
// stub multiplier that returns complex products.
module tb_comp_mult_seq;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic sw_rst;
  logic err;

  comp_mult_seq_if #(.DWIDTH(DW)) bus ();

  comp_mult_seq #(.DWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_rst(sw_rst),
    .bus   (bus.slave),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  // reference model state
  logic [15:0] pend[$];
  logic [35:0] fq[$];
  logic [35:0] mul_q[$];
  int          outst = 0;
  bit          m_hold = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_op_data = 32'd0;
  int          samples_in = 0;

  // stimulus knobs and DUT observation counters
  int p_in = 0, p_op = 0, p_res = 0, p_out = 0;
  int feed_limit = 0;
  int dut_ops = 0;
  int both_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] cmul(input logic [31:0] w);
    int x1, y1, x2, y2, xr, yr;
    logic [17:0] a, b;
    x1 = int'($signed(w[31:24]));
    y1 = int'($signed(w[23:16]));
    x2 = int'($signed(w[15:8]));
    y2 = int'($signed(w[7:0]));
    xr = x1 * x2 - y1 * y2;
    yr = x1 * y2 + y1 * x2;
    a = xr[17:0];
    b = yr[17:0];
    return {a, b};
  endfunction

  function automatic bit m_in_rdy();
    return pend.size() < 2;
  endfunction

  function automatic bit m_op_val();
    return (pend.size() == 2) && (((fq.size() + outst) < DEPTH) || m_hold);
  endfunction

  task automatic model_reset();
    pend.delete();
    fq.delete();
    mul_q.delete();
    outst = 0;
    m_hold = 1'b0;
    m_err = 1'b0;
    m_op_data = 32'd0;
  endtask

  task automatic model_step();
    bit inf, opf, resf, popf;
    int o;
    o    = outst;
    inf  = bus.in_val && m_in_rdy();
    opf  = m_op_val() && bus.op_rdy;
    resf = bus.res_val && (fq.size() < DEPTH);
    popf = bus.out_rdy && (fq.size() != 0);
    m_hold = m_op_val() && !bus.op_rdy;
    if (popf) void'(fq.pop_front());
    if (resf) begin
      fq.push_back(bus.res_data);
      if (mul_q.size() != 0) void'(mul_q.pop_front());
      if (o == 0) m_err = 1'b1;
    end
    outst = o + (opf ? 1 : 0) - ((resf && o != 0) ? 1 : 0);
    if (opf) begin
      mul_q.push_back(cmul(m_op_data));
      pend.delete();
    end
    if (inf) begin
      pend.push_back(bus.in_data);
      samples_in++;
      if (pend.size() == 2) m_op_data = {pend[0], pend[1]};
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || sw_rst) model_reset();
    else model_step();
  end

  // cycle compare against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("in_rdy",   bus.in_rdy,   m_in_rdy());
      chk("op_val",   bus.op_val,   m_op_val());
      chk("op_data",  bus.op_data,  m_op_data);
      chk("res_rdy",  bus.res_rdy,  fq.size() < DEPTH);
      chk("out_val",  bus.out_val,  fq.size() != 0);
      chk("out_data", bus.out_data, (fq.size() != 0) ? fq[0] : 36'd0);
      chk("err",      err,          m_err);
    end
  end

  always @(negedge clk) begin
    if (rst_n && !sw_rst) begin
      if (bus.op_val && bus.op_rdy) dut_ops++;
      if (bus.res_val && bus.res_rdy && bus.out_val && bus.out_rdy) both_cnt++;
    end
  end

  task automatic idle();
    bus.in_val = 1'b0;
    bus.in_data = 16'd0;
    bus.op_rdy = 1'b0;
    bus.res_val = 1'b0;
    bus.res_data = 36'd0;
    bus.out_rdy = 1'b0;
  endtask

  task automatic drive();
    bus.in_val  = (samples_in < feed_limit) && (int'($urandom_range(99)) < p_in);
    bus.in_data = 16'($urandom);
    bus.op_rdy  = int'($urandom_range(99)) < p_op;
    bus.out_rdy = int'($urandom_range(99)) < p_out;
    if (mul_q.size() != 0 && int'($urandom_range(99)) < p_res) begin
      bus.res_val  = 1'b1;
      bus.res_data = mul_q[0];
    end else begin
      bus.res_val  = 1'b0;
      bus.res_data = 36'($urandom);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic set_knobs(input int a, input int b, input int c, input int d);
    p_in = a; p_op = b; p_res = c; p_out = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_rdy"},   bus.in_rdy,   1'b1);
    chk({tag, "_op_val"},   bus.op_val,   1'b0);
    chk({tag, "_op_data"},  bus.op_data,  32'd0);
    chk({tag, "_res_rdy"},  bus.res_rdy,  1'b1);
    chk({tag, "_out_val"},  bus.out_val,  1'b0);
    chk({tag, "_out_data"}, bus.out_data, 36'd0);
    chk({tag, "_err"},      err,          1'b0);
  endtask

  // two ops complete with results held in the FIFO and a third pair waiting in issue
  task automatic setup_issue_with_two();
    set_knobs(100, 100, 100, 0);
    feed_limit = samples_in + 4;
    run(20);
    set_knobs(100, 0, 100, 0);
    feed_limit = samples_in + 2;
    run(8);
    idle();
    chk("setup_op_val", bus.op_val, 1'b1);
    chk("setup_in_rdy", bus.in_rdy, 1'b0);
    chk("setup_out_val", bus.out_val, 1'b1);
  endtask

  initial begin
    int ops0;
    rst_n = 1'b0;
    sw_rst = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmp_on = 1'b1;
    chk_reset_vals("rst");

    // (1,2)*(3,4) = -5 + j10
    bus.in_val = 1'b1;
    bus.in_data = 16'h0102;
    @(posedge clk); #1;
    bus.in_data = 16'h0304;
    @(posedge clk); #1;
    bus.in_val = 1'b0;
    chk("t1_op_val", bus.op_val, 1'b1);
    chk("t1_op_data", bus.op_data, 32'h01020304);
    bus.op_rdy = 1'b1;
    @(posedge clk); #1;
    bus.op_rdy = 1'b0;
    chk("t1_op_val_low", bus.op_val, 1'b0);
    chk("t1_product", (mul_q.size() != 0) ? mul_q[0] : 36'd0, 36'hFFFEC000A);
    chk("t1_out_val_pre", bus.out_val, 1'b0);
    bus.res_val = 1'b1;
    bus.res_data = 36'hFFFEC000A;
    @(posedge clk); #1;
    bus.res_val = 1'b0;
    chk("t1_out_val", bus.out_val, 1'b1);
    chk("t1_out_data", bus.out_data, 36'hFFFEC000A);
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    bus.out_rdy = 1'b0;
    chk("t1_drained", bus.out_val, 1'b0);

    // back-pressure: 10 samples, only 4 ops until the FIFO drains
    ops0 = dut_ops;
    set_knobs(100, 100, 100, 0);
    feed_limit = samples_in + 10;
    run(40);
    idle();
    chk("t2_ops_blocked", dut_ops - ops0, 4);
    chk("t2_op_val", bus.op_val, 1'b0);
    chk("t2_res_rdy", bus.res_rdy, 1'b0);
    chk("t2_out_val", bus.out_val, 1'b1);
    set_knobs(100, 100, 100, 100);
    run(30);
    idle();
    chk("t2_ops_all", dut_ops - ops0, 5);
    chk("t2_out_val_end", bus.out_val, 1'b0);

    // result burst with continuous draining, 9 ops across pointer wrap
    ops0 = dut_ops;
    both_cnt = 0;
    set_knobs(100, 100, 0, 100);
    feed_limit = samples_in + 18;
    run(15);
    set_knobs(100, 100, 100, 100);
    run(60);
    idle();
    chk("t3_ops", dut_ops - ops0, 9);
    chk("t3_push_pop", both_cnt > 0, 1'b1);
    chk("t3_empty", bus.out_val, 1'b0);

    // unsolicited result
    chk("t4_err_pre", err, 1'b0);
    bus.res_val = 1'b1;
    bus.res_data = 36'h123456789;
    @(posedge clk); #1;
    bus.res_val = 1'b0;
    chk("t4_err", err, 1'b1);
    chk("t4_out_val", bus.out_val, 1'b1);
    chk("t4_out_data", bus.out_data, 36'h123456789);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_err_sticky", err, 1'b1);
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    chk("t4_err_clr", err, 1'b0);
    chk("t4_fifo_clr", bus.out_val, 1'b0);

    // asynchronous reset in issue state with two results buffered
    setup_issue_with_two();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // synchronous reset in the same situation, colliding with an op handshake
    setup_issue_with_two();
    sw_rst = 1'b1;
    bus.op_rdy = 1'b1;
    #1;
    chk("srst_not_yet", bus.op_val, 1'b1);
    @(posedge clk); #1;
    sw_rst = 1'b0;
    bus.op_rdy = 1'b0;
    chk_reset_vals("srst");

    // one sample then a gap: waits in S_B
    bus.in_val = 1'b1;
    bus.in_data = 16'hABCD;
    @(posedge clk); #1;
    bus.in_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t6_in_rdy", bus.in_rdy, 1'b1);
      chk("t6_op_val", bus.op_val, 1'b0);
    end
    bus.in_val = 1'b1;
    bus.in_data = 16'h1234;
    @(posedge clk); #1;
    bus.in_val = 1'b0;
    chk("t6_op_val_rise", bus.op_val, 1'b1);
    chk("t6_op_data", bus.op_data, 32'hABCD1234);
    bus.op_rdy = 1'b1;
    @(posedge clk); #1;
    bus.op_rdy = 1'b0;

    // random traffic
    feed_limit = samples_in + 100000;
    for (int blk = 0; blk < 15; blk++) begin
      set_knobs(int'($urandom_range(10, 100)), int'($urandom_range(10, 100)),
                int'($urandom_range(10, 100)), int'($urandom_range(0, 100)));
      run(100);
    end
    set_knobs(0, 100, 100, 100);
    run(60);
    idle();
    chk("end_out_val", bus.out_val, 1'b0);
    chk("end_err", err, 1'b0);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
